// File: rtl/inst_bus_mr_if.sv
// Instruction-bus requester interface for inst_bus_mr.
//   master : the requester (drives address/data/strobes, sees stall/error/read data)
//   slave  : inst_bus_mr (sees the request, returns stall/error/read data)
// Ports:
//   dev_access_addr        request address, held stable while stalled
//   dev_access_byte_enable byte lanes for writes
//   dev_access_read        read request
//   dev_access_write       write request
//   dev_access_write_data  write data
//   dev_access_read_data   registered read data
//   inst_bus_stall         requester must hold its request
//   inst_bus_error         access faulted, valid with the completion
interface inst_bus_mr_if;
    logic [31:0] dev_access_addr;
    logic [3:0]  dev_access_byte_enable;
    logic        dev_access_read;
    logic        dev_access_write;
    logic [31:0] dev_access_write_data;
    logic [31:0] dev_access_read_data;
    logic        inst_bus_stall;
    logic        inst_bus_error;

    modport master (
        output dev_access_addr,
        output dev_access_byte_enable,
        output dev_access_read,
        output dev_access_write,
        output dev_access_write_data,
        input  dev_access_read_data,
        input  inst_bus_stall,
        input  inst_bus_error
    );

    modport slave (
        input  dev_access_addr,
        input  dev_access_byte_enable,
        input  dev_access_read,
        input  dev_access_write,
        input  dev_access_write_data,
        output dev_access_read_data,
        output inst_bus_stall,
        output inst_bus_error
    );
endinterface

// File: rtl/inst_bus_mr.sv
// Instruction-bus router: decodes a requester access to either a boot ROM
// (synchronous, one cycle, read-only) or an SRAM with fixed latency plus wait
// requests. Unmapped accesses, ROM writes and simultaneous read+write fault.
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   bus                 requester interface (slave modport)
//   bootrom_addr        ROM word address, held outside ROM accesses
//   data_from_bootrom   ROM read data
//   ram_addr            SRAM address
//   ram_read_data       SRAM read data
//   ram_write_data      SRAM write data
//   ram_byte_enable     SRAM byte lanes (all lanes on reads)
//   ram_read_enable     SRAM read strobe
//   ram_write_enable    SRAM write strobe
//   ram_stall           SRAM wait request
// RAM_LATENCY must lie in 1..15 (4-bit cycle counter).
module inst_bus_mr #(
    parameter logic [11:0] BOOT_ADDR_PREFIX = 12'h1fc,
    parameter logic [7:0]  RAM_ADDR_PREFIX  = 8'h00,
    parameter int unsigned ROM_ADDR_WIDTH   = 13,
    parameter int unsigned RAM_ADDR_WIDTH   = 24,
    parameter int unsigned RAM_LATENCY      = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    inst_bus_mr_if.slave              bus,
    output logic [ROM_ADDR_WIDTH-1:0] bootrom_addr,
    input  logic [31:0]               data_from_bootrom,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    input  logic [31:0]               ram_read_data,
    output logic [31:0]               ram_write_data,
    output logic [3:0]                ram_byte_enable,
    output logic                      ram_read_enable,
    output logic                      ram_write_enable,
    input  logic                      ram_stall
);

    localparam logic [3:0] LatencyInit = 4'(RAM_LATENCY);

    typedef enum logic [1:0] {StIdle, StRamAccess, StRomAccess, StDone} state_e;

    state_e                    state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]               wdata_q, wdata_d;
    logic [3:0]                be_q, be_d;
    logic                      write_q, write_d;
    logic [31:0]               rdata_q, rdata_d;
    logic [ROM_ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic                      error_q, error_d;
    logic                      stall;

    logic req, ram_hit, boot_hit;
    assign req      = bus.dev_access_read | bus.dev_access_write;
    assign ram_hit  = bus.dev_access_addr[31:24] == RAM_ADDR_PREFIX;
    assign boot_hit = bus.dev_access_addr[31:20] == BOOT_ADDR_PREFIX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            write_q    <= 1'b0;
            rdata_q    <= 32'd0;
            rom_addr_q <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            write_q    <= write_d;
            rdata_q    <= rdata_d;
            rom_addr_q <= rom_addr_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        be_d             = be_q;
        write_d          = write_q;
        rdata_d          = rdata_q;
        rom_addr_d       = rom_addr_q;
        error_d          = 1'b0;  // error is a one-cycle pulse that lives only in StDone
        stall            = 1'b0;
        ram_read_enable  = 1'b0;
        ram_write_enable = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    stall   = 1'b1;
                    addr_d  = bus.dev_access_addr[RAM_ADDR_WIDTH-1:0];
                    wdata_d = bus.dev_access_write_data;
                    be_d    = bus.dev_access_byte_enable;
                    write_d = bus.dev_access_write;
                    // Decode straight from the request so a fault completes one cycle later.
                    // RAM is tested first so it wins when both prefixes match.
                    if (bus.dev_access_read && bus.dev_access_write) begin
                        state_d = StDone;
                        error_d = 1'b1;
                        rdata_d = 32'd0;
                    end else if (ram_hit) begin
                        state_d = StRamAccess;
                        cnt_d   = LatencyInit;
                    end else if (boot_hit && bus.dev_access_read) begin
                        state_d    = StRomAccess;
                        rom_addr_d = bus.dev_access_addr[ROM_ADDR_WIDTH+1:2];
                    end else begin
                        // Any fault, including a ROM write, reports zero read data.
                        state_d = StDone;
                        error_d = 1'b1;
                        rdata_d = 32'd0;
                    end
                end
            end
            StRamAccess: begin
                stall            = 1'b1;
                ram_read_enable  = !write_q;
                ram_write_enable = write_q;
                if (!ram_stall) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = StDone;
                        if (!write_q) begin
                            rdata_d = ram_read_data;
                        end
                    end
                end
            end
            StRomAccess: begin
                stall   = 1'b1;
                rdata_d = data_from_bootrom;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.inst_bus_stall       = stall;
    assign bus.inst_bus_error       = error_q;
    assign bus.dev_access_read_data = rdata_q;
    assign bootrom_addr             = rom_addr_q;
    assign ram_addr                 = addr_q;
    assign ram_write_data           = wdata_q;
    assign ram_byte_enable          = write_q ? be_q : 4'b1111;

endmodule

// File: doc/inst_bus_mr.md
INST_BUS_MR -- requirements
Module: inst_bus_mr

Interface
REQ-001 SHALL have parameter BOOT_ADDR_PREFIX, default 12'h1fc, boot ROM region match on address bits [31:20].
REQ-002 SHALL have parameter RAM_ADDR_PREFIX, default 8'h00, SRAM region match on address bits [31:24].
REQ-003 SHALL have parameter ROM_ADDR_WIDTH, default 13, boot ROM word-address width.
REQ-004 SHALL have parameter RAM_ADDR_WIDTH, default 24, SRAM address width.
REQ-005 SHALL have parameter RAM_LATENCY, default 2, SRAM access cycles, legal range 1..15.
REQ-006 SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  clock, all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- dev_access_addr  in  32  request address, held stable while stalled
- dev_access_byte_enable  in  4  byte lanes for writes
- dev_access_read  in  1  read request
- dev_access_write  in  1  write request
- dev_access_write_data  in  32  write data
- dev_access_read_data  out  32  registered read data
- inst_bus_stall  out  1  requester must hold its request
- inst_bus_error  out  1  access faulted, valid with the completion
- bootrom_addr  out  ROM_ADDR_WIDTH  ROM address
- data_from_bootrom  in  32  ROM data, synchronous, one cycle
- ram_addr  out  RAM_ADDR_WIDTH  SRAM address
- ram_read_data  in  32  SRAM read data
- ram_write_data  out  32  SRAM write data
- ram_byte_enable  out  4  SRAM byte lanes
- ram_read_enable  out  1  SRAM read strobe
- ram_write_enable  out  1  SRAM write strobe
- ram_stall  in  1  SRAM wait request

Function
REQ-007 SHALL implement a registered FSM with states IDLE, RAM_ACCESS, ROM_ACCESS, DONE.
REQ-008 In IDLE with read or write asserted, the block SHALL drive inst_bus_stall=1 combinationally and latch addr/data/byte_enable/direction.
REQ-009 SHALL decode the latched request:
- RAM match -> RAM_ACCESS.
- BOOT match and read -> ROM_ACCESS.
- Anything else (unmapped address, ROM write, read and write both asserted) -> DONE with error flagged; no device strobe.
REQ-010 RAM match SHALL take priority if both prefixes match.
REQ-011 In RAM_ACCESS:
- ram_read_enable or ram_write_enable SHALL be asserted from latched direction, with ram_addr=latched addr[RAM_ADDR_WIDTH-1:0].
- Writes SHALL carry ram_byte_enable=latched byte_enable; reads SHALL carry 4'b1111.
- A 4-bit counter SHALL load RAM_LATENCY on entry and decrement only in cycles with ram_stall=0.
- Exit to DONE SHALL occur in the cycle the counter is 1 and ram_stall=0, capturing ram_read_data for reads.
REQ-012 In ROM_ACCESS (exactly one cycle), bootrom_addr SHALL equal latched addr[ROM_ADDR_WIDTH+1:2]; data_from_bootrom SHALL be captured on exit to DONE.
REQ-013 Outside ROM_ACCESS, bootrom_addr SHALL hold its last value; ram strobes SHALL be 0 outside RAM_ACCESS.
REQ-014 inst_bus_stall SHALL be 1 in RAM_ACCESS and ROM_ACCESS, 0 in DONE, and 0 in IDLE with no request.
REQ-015 DONE SHALL last one cycle, then return to IDLE; dev_access_read_data SHALL be valid in DONE and held until the next capture.
REQ-016 inst_bus_error SHALL be 1 only in DONE of a faulted access; faulted reads SHALL return 32'h0.
REQ-017 Writes SHALL leave dev_access_read_data unchanged.
REQ-018 Latency (request cycle T):
- ROM read completes in DONE at T+2.
- RAM access with no ram_stall completes at T+RAM_LATENCY+1.
- Fault completes at T+1.
- Each ram_stall cycle adds one cycle.

Reset
REQ-019 On rst_n=0, the block SHALL immediately (asynchronously) enter IDLE and zero the counter, dev_access_read_data, latched registers, bootrom_addr, and error.
REQ-020 Reset mid-RAM_ACCESS SHALL deassert ram strobes in the same cycle; no completion SHALL be reported for the aborted access.

Verification
REQ-021 ROM read of addr 32'h1fc00010, ROM returns 32'hdeadbeef -> bootrom_addr=4, stall 1,1,0, read_data=32'hdeadbeef in T+2, error=0.
REQ-022 RAM read of 32'h00000040, RAM_LATENCY=2, ram_read_data=32'h12345678, ram_stall=1 for one cycle -> ram_read_enable high for 3 cycles, DONE at T+4, read_data=32'h12345678.
REQ-023 RAM write of 32'h000000a0, byte_enable 4'b0011, data 32'hcafe0001 -> ram_write_enable=1, ram_byte_enable=4'b0011, ram_write_data=32'hcafe0001, read_data unchanged.
REQ-024 Read of unmapped 32'h80000000, ROM write to 32'h1fc00000, and read+write both asserted -> each gives DONE at T+1 with error=1, read_data=0, no strobes.
REQ-025 rst_n low during the second RAM_ACCESS cycle -> strobes 0 immediately, state IDLE, read_data=0; a following ROM read completes normally.
